// File: rtl/mem_stage.sv
// mem_stage: LC-3b memory-access stage. Issues data-memory reads/writes over a
// request/response handshake, sequences LDI/STI indirection, and hands
// registered results to write-back with a one-cycle wb_valid pulse.

package lc3b_types;
  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LDB = 4'b0010, OP_STB  = 4'b0011,
    OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR  = 4'b0111,
    OP_RTI = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI  = 4'b1011,
    OP_JMP = 4'b1100, OP_SHF = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
  } lc3b_opcode;

  typedef struct packed {
    lc3b_opcode  opcode;
    logic [2:0]  nzp;
    logic [2:0]  dr;
    logic        load_regfile;
    logic        load_cc;
  } lc3b_ipacket;

  // Bubble packet: a BR that never branches and writes nothing.
  localparam lc3b_ipacket NOP_PACKET = '{opcode: OP_BR, nzp: 3'b000, dr: 3'b000,
                                         load_regfile: 1'b0, load_cc: 1'b0};
endpackage

module mem_stage
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  lc3b_ipacket ex_ipacket,
  input  logic [15:0] ex_alu,
  input  logic [15:0] ex_br_addr,
  input  logic [15:0] ex_sr_data,
  input  logic        pip_flush,
  output logic        stall,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic        dmem_read,
  output logic        dmem_write,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [15:0] mem_out,
  output logic [15:0] alu_out,
  output logic [15:0] br_addr_out,
  output lc3b_ipacket ipacket_out,
  output logic        wb_valid
);

  typedef enum logic [1:0] {IDLE, MEM1, MEM2} state_t;

  state_t      state_q;
  lc3b_ipacket pkt_q;
  lc3b_word    alu_q, br_q, sr_q;
  lc3b_word    addr_q, wdata_q;
  logic [1:0]  be_q;
  logic        rd_q, wr_q;
  lc3b_word    mem_out_q, alu_out_q, br_out_q;
  lc3b_ipacket ipkt_out_q;
  logic        wb_valid_q;
  logic        done;

  function automatic logic is_mem_op(input lc3b_opcode op);
    return (op == OP_LDR) || (op == OP_LDB) || (op == OP_LDI) ||
           (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
  endfunction

  function automatic logic is_indirect(input lc3b_opcode op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

  function automatic logic is_byte_op(input lc3b_opcode op);
    return (op == OP_LDB) || (op == OP_STB);
  endfunction

  function automatic lc3b_word word_addr(input lc3b_word a);
    return {a[15:1], 1'b0};
  endfunction

  function automatic logic [1:0] byte_en(input logic byte_op, input logic a0);
    if (!byte_op) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

  // Data handed to write-back on completion; stores deliver zero.
  function automatic lc3b_word load_data(input lc3b_opcode op, input logic a0,
                                         input lc3b_word rdata);
    case (op)
      OP_LDR, OP_LDI: return rdata;
      OP_LDB:         return a0 ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
      default:        return 16'h0000;
    endcase
  endfunction

  // Final handshake of the current instruction completes on this edge.
  always_comb begin
    done = 1'b0;
    if (dmem_resp) begin
      done = (state_q == MEM2) || ((state_q == MEM1) && !is_indirect(pkt_q.opcode));
    end
  end

  // Stage FSM with registered memory requests and write-back outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pkt_q      <= NOP_PACKET;
      alu_q      <= '0;
      br_q       <= '0;
      sr_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 2'b00;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      mem_out_q  <= '0;
      alu_out_q  <= '0;
      br_out_q   <= '0;
      ipkt_out_q <= NOP_PACKET;
      wb_valid_q <= 1'b0;
    end else begin
      // Any cycle that completes nothing hands a bubble to write-back.
      mem_out_q  <= '0;
      alu_out_q  <= '0;
      br_out_q   <= '0;
      ipkt_out_q <= NOP_PACKET;
      wb_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (ex_valid && !pip_flush) begin
            pkt_q <= ex_ipacket;
            alu_q <= ex_alu;
            br_q  <= ex_br_addr;
            sr_q  <= ex_sr_data;
            if (is_mem_op(ex_ipacket.opcode)) begin
              state_q <= MEM1;
              addr_q  <= is_byte_op(ex_ipacket.opcode) ? ex_alu : word_addr(ex_alu);
              be_q    <= byte_en(is_byte_op(ex_ipacket.opcode), ex_alu[0]);
              wdata_q <= (ex_ipacket.opcode == OP_STB) ?
                         {ex_sr_data[7:0], ex_sr_data[7:0]} : ex_sr_data;
              // LDI/STI both begin by fetching the pointer word.
              wr_q    <= (ex_ipacket.opcode == OP_STR) || (ex_ipacket.opcode == OP_STB);
              rd_q    <= !((ex_ipacket.opcode == OP_STR) || (ex_ipacket.opcode == OP_STB));
            end else begin
              ipkt_out_q <= ex_ipacket;
              alu_out_q  <= ex_alu;
              br_out_q   <= ex_br_addr;
              wb_valid_q <= 1'b1;
            end
          end
        end
        MEM1: begin
          if (dmem_resp && is_indirect(pkt_q.opcode)) begin
            state_q <= MEM2;
            addr_q  <= word_addr(dmem_rdata);
            be_q    <= 2'b11;
            wdata_q <= sr_q;
            rd_q    <= (pkt_q.opcode == OP_LDI);
            wr_q    <= (pkt_q.opcode == OP_STI);
          end
        end
        MEM2: ;
        default: state_q <= IDLE;
      endcase

      if (done) begin
        state_q    <= IDLE;
        rd_q       <= 1'b0;
        wr_q       <= 1'b0;
        addr_q     <= '0;
        wdata_q    <= '0;
        be_q       <= 2'b00;
        mem_out_q  <= load_data(pkt_q.opcode, alu_q[0], dmem_rdata);
        alu_out_q  <= alu_q;
        br_out_q   <= br_q;
        ipkt_out_q <= pkt_q;
        wb_valid_q <= 1'b1;
      end
    end
  end

  assign stall            = (state_q != IDLE);
  assign dmem_address     = addr_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_byte_enable = be_q;
  assign dmem_read        = rd_q;
  assign dmem_write       = wr_q;
  assign mem_out          = mem_out_q;
  assign alu_out          = alu_out_q;
  assign br_addr_out      = br_out_q;
  assign ipacket_out      = ipkt_out_q;
  assign wb_valid         = wb_valid_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined LC-3b core, sitting directly upstream of the write-back stage. It accepts one instruction packet per transaction from execute, performs data-memory reads and writes over a request/response handshake, and sequences the two-access LDI/STI indirect forms. It delivers registered `mem_out`, `alu_out`, `br_addr_out` and `ipacket_out` to write-back, and holds the pipeline with `stall` while an access is outstanding.

## Interface
- No parameters. Widths are fixed by `lc3b_types`.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  execute presents a valid packet this cycle.
- `ex_ipacket`  in  `lc3b_ipacket`  instruction packet from execute.
- `ex_alu`  in  16  ALU result; this is the effective address for memory ops.
- `ex_br_addr`  in  16  branch/PC-relative target.
- `ex_sr_data`  in  16  store source register value.
- `pip_flush`  in  1  flush request from write-back.
- `stall`  out  1  stage busy; upstream must hold its packet.
- `dmem_address`  out  16  data memory address.
- `dmem_wdata`  out  16  data memory write data.
- `dmem_byte_enable`  out  2  byte enables; bit 1 is the high byte.
- `dmem_read`  out  1  read request.
- `dmem_write`  out  1  write request.
- `dmem_rdata`  in  16  read data; valid only when `dmem_resp` is high.
- `dmem_resp`  in  1  access complete.
- `mem_out`  out  16  loaded data to write-back.
- `alu_out`  out  16  registered ALU result.
- `br_addr_out`  out  16  registered branch target.
- `ipacket_out`  out  `lc3b_ipacket`  registered packet.
- `wb_valid`  out  1  write-back registers hold a real instruction this cycle.

## Operation
- FSM states:
  - IDLE: no access outstanding.
  - MEM1: first or only access.
  - MEM2: second access of LDI/STI.
- `stall` = (state != IDLE).
- Accept condition: IDLE && `ex_valid` && !`pip_flush`. On accept, latch the packet, `ex_alu`, `ex_br_addr` and `ex_sr_data` into internal holding registers.
- Non-memory opcodes (anything other than LDR, LDB, LDI, STR, STB, STI):
  - Output registers load at the accept edge, with `mem_out` = 0 and `wb_valid` = 1.
  - State stays IDLE.
- Memory opcodes:
  - Accept edge moves the FSM to MEM1 and loads a bubble into the output registers.
  - Bubble: `wb_valid` = 0; `ipacket_out` is a NOP packet (opcode BR, nzp = 000, `load_regfile` = 0, `load_cc` = 0); data outputs are 0. Write-back therefore raises no flush and writes no state.
- Address rules:
  - Word accesses force `dmem_address[0]` = 0 and `dmem_byte_enable` = 11.
  - Byte accesses use the full address; `dmem_byte_enable` = 10 if addr[0] = 1, else 01.
- MEM1, per opcode:
  - LDR: read at `ex_alu`.
  - LDB: read; `mem_out` = selected byte (high byte if addr[0] = 1), zero-extended.
  - STR: write `ex_sr_data`.
  - STB: write {sr[7:0], sr[7:0]}.
  - LDI/STI: word read at `ex_alu`; the returned word is captured as the indirect address.
- MEM2:
  - LDI: word read at the indirect address.
  - STI: word write of `ex_sr_data` to the indirect address.
- Completion:
  - On `dmem_resp` in the final state (MEM1 for single-access ops, MEM2 for LDI/STI), load the output registers with `wb_valid` = 1 and return to IDLE.
  - Loads write `mem_out`; stores write `mem_out` = 0.
- Requests stay asserted and stable (address, data, enables) from state entry until `dmem_resp`.
  - `dmem_read` and `dmem_write` are never both high.
  - Both are 0 in IDLE.
- Every cycle that does not complete an instruction loads the bubble, so `wb_valid` pulses once per instruction.
- `pip_flush` only gates acceptance. While busy, a flush cannot originate from write-back, because it holds only bubbles. `pip_flush` while busy is ignored.

## Timing
- Reset (async assert, sync deassert sampling):
  - state = IDLE, `stall` = 0.
  - `dmem_read` = `dmem_write` = 0, `dmem_address` = `dmem_wdata` = 0, `dmem_byte_enable` = 00.
  - `mem_out` = `alu_out` = `br_addr_out` = 0, `ipacket_out` = NOP, `wb_valid` = 0.
- Reset mid-access drops the request the same cycle. The access is abandoned and nothing reaches write-back.
- Non-memory latency: 1 cycle, with no stall.
- Single access accepted at edge t, `dmem_resp` seen at edge t+k (k ≥ 1): result valid at write-back in cycle t+k; `stall` high for cycles t..t+k-1.
- LDI/STI: two back-to-back handshakes. MEM2 requests start the cycle after the MEM1 response.
- A `dmem_resp` that arrives while IDLE is ignored.
- A new packet can be accepted in the first cycle after completion.

## Test plan
- ADD with `ex_alu` = 0x1234: one cycle later `alu_out` = 0x1234, `wb_valid` = 1, `stall` never high.
- LDR at 0x3001 with resp after 3 cycles and rdata 0xBEEF: address 0x3000, enables 11, `stall` high 3 cycles, `mem_out` = 0xBEEF, `wb_valid` high for exactly one cycle.
- LDB at 0x4001 with rdata 0xA55A: `mem_out` = 0x00A5. STB at 0x4000 with sr 0x12CD: wdata 0xCDCD, enables 01.
- LDI at 0x5000; first resp returns 0x6000, second returns 0x0042: second read address 0x6000, `mem_out` = 0x0042. STI drives a write to 0x6000 with sr data.
- `ex_valid` high together with `pip_flush` in IDLE: packet not accepted, no request issued, `wb_valid` = 0.
- `rst_n` pulled low during MEM2 of an STI: `dmem_write` drops immediately, and after release state is IDLE, `wb_valid` = 0, `stall` = 0.
